// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: funct3 size/sign encodings, MEM stage FSM states and the access-size helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   // log2 of the access size in bytes; reserved encodings fall back to the full data width
   function automatic logic [1:0] acc_size(input logic [2:0] f3, input int xlen);
      logic [1:0] full;
      full = (xlen == 64) ? 2'd3 : 2'd2;
      case (f3)
         F3_B, F3_BU: acc_size = 2'd0;
         F3_H, F3_HU: acc_size = 2'd1;
         F3_W:        acc_size = 2'd2;
         F3_WU:       acc_size = (xlen == 64) ? 2'd2 : full;
         default:     acc_size = full;
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte strobes and lane-replicated store data, plus load shift and sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; the caller holds inputs stable for as long as it needs the outputs.
module load_store_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NB   = XLEN / 8,
   parameter int OFF_W = $clog2(NB)
)
(
   input  logic [OFF_W-1:0] off_i,
   input  logic [2:0]       funct3_i,
   input  logic [XLEN-1:0]  st_data_i,
   input  logic [XLEN-1:0]  ld_raw_i,
   output logic [NB-1:0]    wstrb_o,
   output logic [XLEN-1:0]  wdata_o,
   output logic [XLEN-1:0]  ld_data_o
);

   logic [1:0]      sz;
   int              nbytes;
   int              nbits;
   int              off;
   logic            sgn;
   logic            sbit;
   logic [XLEN-1:0] sh;

   // Size decode, natural alignment of the offset, strobe/replication and load extension
   always_comb begin
      sz     = acc_size(funct3_i, XLEN);
      nbytes = 1 << sz;
      nbits  = 8 * nbytes;
      // offset bits below the access size are dropped so every access is naturally aligned
      off    = int'(off_i) & ~(nbytes - 1);
      sgn    = ~funct3_i[2];

      wstrb_o = '0;
      for (int b = 0; b < NB; b++) begin
         wstrb_o[b] = (b >= off) && (b < off + nbytes);
      end

      case (sz)
         2'd0:    wdata_o = {NB{st_data_i[7:0]}};
         2'd1:    wdata_o = {(NB/2){st_data_i[15:0]}};
         2'd2:    wdata_o = {(NB/4){st_data_i[31:0]}};
         default: wdata_o = st_data_i;
      endcase

      sh = ld_raw_i >> (8 * off);
      case (sz)
         2'd0:    sbit = sh[7];
         2'd1:    sbit = sh[15];
         2'd2:    sbit = sh[31];
         default: sbit = sh[XLEN-1];
      endcase

      ld_data_o = '0;
      for (int i = 0; i < XLEN; i++) begin
         ld_data_o[i] = (i < nbits) ? sh[i] : (sgn & sbit);
      end
   end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: pipeline MEM stage; B/H/W/D loads and stores to RAM over req/ack, controls passed to WB.
// Latency: 1 cycle for non-memory ops, 2 + RAM wait cycles for loads/stores (out_valid one-cycle pulse).
// Backpressure: in_ready low while an access is outstanding; MEM_MISALIGN_TRAP_EN adds misalign trap + out_misaligned.
module memory_access_unit
   import mem_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [XLEN-1:0]       data_in,
   input  logic [2:0]            funct3,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  in_MemToReg,
   input  logic                  in_RegWrite,
   input  logic                  in_RegDataSrc,
   input  logic                  in_PCSrc,
   input  logic [REG_ADDR_W-1:0] in_RegDest,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [XLEN/8-1:0]     mem_wstrb,
   output logic [XLEN-1:0]       mem_write_data,
   input  logic                  mem_ack,
   input  logic [XLEN-1:0]       mem_read_data,
   output logic                  out_valid,
   output logic [XLEN-1:0]       data_out,
   output logic [ADDR_W-1:0]     out_AluResult,
   output logic                  out_MemToReg,
   output logic                  out_RegWrite,
   output logic                  out_RegDataSrc,
   output logic                  out_PCSrc,
   output logic [REG_ADDR_W-1:0] out_RegDest
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  out_misaligned
`endif
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   state_e                  state_q, state_d;
   logic                    accept;
   logic                    mem_op;
   logic                    trap;

   // request captured at accept; stays stable for the whole RAM access
   logic [ADDR_W-1:0]       addr_q;
   logic [XLEN-1:0]         sdata_q;
   logic [2:0]              f3_q;
   logic                    rd_q, wr_q;
   logic                    mtr_q, rw_q, rds_q, pcs_q;
   logic [REG_ADDR_W-1:0]   rdst_q;
   logic                    mem_req_q, mem_we_q;

   // writeback outputs, held until the next out_valid
   logic                    out_valid_q;
   logic [XLEN-1:0]         data_out_q;
   logic [ADDR_W-1:0]       alu_q;
   logic                    o_mtr_q, o_rw_q, o_rds_q, o_pcs_q;
   logic [REG_ADDR_W-1:0]   o_rdst_q;

   logic [NB-1:0]           strb;
   logic [XLEN-1:0]         wdata;
   logic [XLEN-1:0]         ld_data;

   assign mem_op = MemRead | MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
   logic                    mis_q;
   assign trap = mem_op &&
                 ((int'(addr[OFF_W-1:0]) & ((1 << acc_size(funct3, XLEN)) - 1)) != 0);
   assign out_misaligned = mis_q;
`else
   assign trap = 1'b0;
`endif

   load_store_align #(.XLEN(XLEN)) u_align (
      .off_i     (addr_q[OFF_W-1:0]),
      .funct3_i  (f3_q),
      .st_data_i (sdata_q),
      .ld_raw_i  (mem_read_data),
      .wstrb_o   (strb),
      .wdata_o   (wdata),
      .ld_data_o (ld_data)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state: leave IDLE only for a memory op that reaches RAM, leave WAIT on ack
   always_comb begin
      state_d  = state_q;
      in_ready = (state_q == S_IDLE);
      accept   = in_valid & in_ready;
      case (state_q)
         S_IDLE:  if (accept && mem_op && !trap) state_d = S_WAIT;
         S_WAIT:  if (mem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture, RAM handshake and writeback result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         sdata_q     <= '0;
         f3_q        <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         mtr_q       <= 1'b0;
         rw_q        <= 1'b0;
         rds_q       <= 1'b0;
         pcs_q       <= 1'b0;
         rdst_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         alu_q       <= '0;
         o_mtr_q     <= 1'b0;
         o_rw_q      <= 1'b0;
         o_rds_q     <= 1'b0;
         o_pcs_q     <= 1'b0;
         o_rdst_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q       <= 1'b0;
`endif
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            addr_q  <= addr;
            sdata_q <= data_in;
            f3_q    <= funct3;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            mtr_q   <= in_MemToReg;
            rw_q    <= in_RegWrite;
            rds_q   <= in_RegDataSrc;
            pcs_q   <= in_PCSrc;
            rdst_q  <= in_RegDest;
            if (mem_op && !trap) begin
               mem_req_q <= 1'b1;
               mem_we_q  <= MemWrite;
            end else begin
               // ALU-only op or trapped access completes directly
               out_valid_q <= 1'b1;
               data_out_q  <= '0;
               alu_q       <= addr;
               o_mtr_q     <= in_MemToReg;
               o_rw_q      <= in_RegWrite & ~trap;
               o_rds_q     <= in_RegDataSrc;
               o_pcs_q     <= in_PCSrc;
               o_rdst_q    <= in_RegDest;
`ifdef MEM_MISALIGN_TRAP_EN
               mis_q       <= trap;
`endif
            end
         end else if (state_q == S_WAIT && mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            out_valid_q <= 1'b1;
            // a store wins over a simultaneous load, so it returns no data
            data_out_q  <= (rd_q && !wr_q) ? ld_data : '0;
            alu_q       <= addr_q;
            o_mtr_q     <= mtr_q;
            o_rw_q      <= rw_q;
            o_rds_q     <= rds_q;
            o_pcs_q     <= pcs_q;
            o_rdst_q    <= rdst_q;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
         end
      end
   end

   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign mem_wstrb      = mem_we_q ? strb : '0;
   assign mem_write_data = wdata;

   assign out_valid      = out_valid_q;
   assign data_out       = data_out_q;
   assign out_AluResult  = alu_q;
   assign out_MemToReg   = o_mtr_q;
   assign out_RegWrite   = o_rw_q;
   assign out_RegDataSrc = o_rds_q;
   assign out_PCSrc      = o_pcs_q;
   assign out_RegDest    = o_rdst_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed vectors with hand-computed expectations for the MEM stage.
// Latency: inputs driven and outputs sampled on the falling edge, one step per cycle.
// Backpressure: RAM ack driven directly by the bench at chosen wait counts.
module tb_memory_access_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [2:0]  funct3;
   logic        MemRead, MemWrite;
   logic        in_MemToReg, in_RegWrite, in_RegDataSrc, in_PCSrc;
   logic [4:0]  in_RegDest;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_write_data;
   logic        mem_ack;
   logic [31:0] mem_read_data;
   logic        out_valid;
   logic [31:0] data_out;
   logic [31:0] out_AluResult;
   logic        out_MemToReg, out_RegWrite, out_RegDataSrc, out_PCSrc;
   logic [4:0]  out_RegDest;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        out_misaligned;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   memory_access_unit #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .addr           (addr),
      .data_in        (data_in),
      .funct3         (funct3),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .in_MemToReg    (in_MemToReg),
      .in_RegWrite    (in_RegWrite),
      .in_RegDataSrc  (in_RegDataSrc),
      .in_PCSrc       (in_PCSrc),
      .in_RegDest     (in_RegDest),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wstrb      (mem_wstrb),
      .mem_write_data (mem_write_data),
      .mem_ack        (mem_ack),
      .mem_read_data  (mem_read_data),
      .out_valid      (out_valid),
      .data_out       (data_out),
      .out_AluResult  (out_AluResult),
      .out_MemToReg   (out_MemToReg),
      .out_RegWrite   (out_RegWrite),
      .out_RegDataSrc (out_RegDataSrc),
      .out_PCSrc      (out_PCSrc),
      .out_RegDest    (out_RegDest)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .out_misaligned (out_misaligned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdst);
      in_valid      = 1'b1;
      MemRead       = rd;
      MemWrite      = wr;
      funct3        = f3;
      addr          = a;
      data_in       = d;
      in_RegWrite   = 1'b1;
      in_MemToReg   = rd;
      in_RegDataSrc = 1'b0;
      in_PCSrc      = 1'b0;
      in_RegDest    = rdst;
   endtask

   // issue a load, ack with zero wait, check the formatted result
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
      drive(1'b1, 1'b0, f3, a, 32'h0, 5'd7);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
      mem_ack       = 1'b1;
      mem_read_data = word;
      @(negedge clk);
      mem_ack = 1'b0;
      check({tag, "_vld"}, out_valid, 1);
      check({tag, "_data"}, data_out, exp);
      check({tag, "_reqdrop"}, mem_req, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; addr = '0; data_in = '0; funct3 = '0;
      MemRead = 1'b0; MemWrite = 1'b0; in_MemToReg = 1'b0; in_RegWrite = 1'b0;
      in_RegDataSrc = 1'b0; in_PCSrc = 1'b0; in_RegDest = '0;
      mem_ack = 1'b0; mem_read_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_rdy", in_ready, 1);
      check("rst_req", mem_req, 0);
      check("rst_vld", out_valid, 0);
      check("rst_data", data_out, 0);

      // ALU-only op: latency 1
      drive(1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd5);
      in_PCSrc = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("alu_vld", out_valid, 1);
      check("alu_res", out_AluResult, 32'h1234);
      check("alu_data", data_out, 0);
      check("alu_rw", out_RegWrite, 1);
      check("alu_rd", out_RegDest, 5);
      check("alu_pcs", out_PCSrc, 1);
      check("alu_noreq", mem_req, 0);
      @(negedge clk);
      check("alu_pulse", out_valid, 0);
      check("alu_hold", out_AluResult, 32'h1234);

      // SB 0xAB @0x103, ack after 3 wait cycles
      drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h1234_56AB, 5'd0);
      in_RegWrite = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("sb_req", mem_req, 1);
         check("sb_we", mem_we, 1);
         check("sb_addr", mem_addr, 32'h100);
         check("sb_strb", mem_wstrb, 4'b1000);
         check("sb_wdata", mem_write_data, 32'hABAB_ABAB);
         check("sb_rdy", in_ready, 0);
         check("sb_novld", out_valid, 0);
         if (k == 3) mem_ack = 1'b1;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      check("sb_reqdrop", mem_req, 0);
      check("sb_vld", out_valid, 1);
      check("sb_data", data_out, 0);
      check("sb_alu", out_AluResult, 32'h103);
      check("sb_rdy2", in_ready, 1);

      // SH 0x5678 @0x102
      drive(1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF_5678, 5'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("sh_strb", mem_wstrb, 4'b1100);
      check("sh_wdata", mem_write_data, 32'h5678_5678);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("sh_vld", out_valid, 1);

      // loads with sign/zero extension
      run_load("lb",  3'b000, 32'h102, 32'h0080_0000, 32'hFFFF_FF80);
      check("lb_rd", out_RegDest, 7);
      check("lb_alu", out_AluResult, 32'h102);
      run_load("lbu", 3'b100, 32'h102, 32'h0080_0000, 32'h0000_0080);
      run_load("lh",  3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
      run_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001);

      // MemRead & MemWrite together: store wins, data_out 0
      drive(1'b1, 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd3);
      @(negedge clk);
      in_valid = 1'b0;
      check("rw_we", mem_we, 1);
      check("rw_strb", mem_wstrb, 4'b1111);
      check("rw_wdata", mem_write_data, 32'hCAFE_F00D);
      mem_ack = 1'b1; mem_read_data = 32'h1111_1111;
      @(negedge clk);
      mem_ack = 1'b0;
      check("rw_vld", out_valid, 1);
      check("rw_data", data_out, 0);

      // back-to-back LW, zero-wait RAM
      drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
      check("b2b_rdy0", in_ready, 1);
      @(negedge clk);
      check("b2b_rdy1", in_ready, 0);
      check("b2b_req1", mem_req, 1);
      check("b2b_nv1", out_valid, 0);
      mem_ack = 1'b1; mem_read_data = 32'hA5A5_0001;
      drive(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 5'd10);
      @(negedge clk);
      check("b2b_rdy2", in_ready, 1);
      check("b2b_vld1", out_valid, 1);
      check("b2b_dat1", data_out, 32'hA5A5_0001);
      check("b2b_alu1", out_AluResult, 32'h300);
      check("b2b_reqlo", mem_req, 0);
      mem_ack = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_rdy3", in_ready, 0);
      check("b2b_nv2", out_valid, 0);
      check("b2b_req2", mem_req, 1);
      check("b2b_addr2", mem_addr, 32'h304);
      mem_ack = 1'b1; mem_read_data = 32'h0000_0002;
      @(negedge clk);
      mem_ack = 1'b0;
      check("b2b_vld2", out_valid, 1);
      check("b2b_dat2", data_out, 32'h0000_0002);
      check("b2b_rd2", out_RegDest, 10);

      // misaligned LW @0x102
`ifdef MEM_MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      check("mis_noreq", mem_req, 0);
      check("mis_vld", out_valid, 1);
      check("mis_flag", out_misaligned, 1);
      check("mis_rw", out_RegWrite, 0);
`else
      run_load("lw_mis", 3'b010, 32'h102, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      check("lw_mis_rw", out_RegWrite, 1);
`endif

      // reset mid-WAIT, then a late ack must be ignored
      drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd11);
      @(negedge clk);
      in_valid = 1'b0;
      check("rw8_req", mem_req, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rwait_req", mem_req, 0);
      check("rwait_rdy", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      check("rwait_alu", out_AluResult, 0);
      check("rwait_rw", out_RegWrite, 0);
      check("rwait_rd", out_RegDest, 0);
      check("rwait_data", data_out, 0);
      mem_ack = 1'b1; mem_read_data = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_vld", out_valid, 0);
      check("late_req", mem_req, 0);
      check("late_rdy", in_ready, 1);
      check("late_data", data_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
